// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// A CPU store to TXDATA queues a byte in a circular TX FIFO. A serialiser
// drains the FIFO onto uart_rxd_out. STATUS reports the FIFO fill level and
// the sticky overflow flag, plus busy, empty and full. A store to STATUS
// clears the overflow flag.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high; pops the FIFO head into the shift register if any
// START  | start bit (line low) for CLKS_PER_BIT clocks
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT clocks each
// STOP   | stop bit (line high) for CLKS_PER_BIT clocks
//
// The line is driven from a register fed by the output decode of the current
// state. The serial waveform therefore trails the FSM state by one clock.
// This gives the two-edge store-to-start-bit latency and a glitch-free
// output pin.

module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_sel,
    output logic [31:0] bus_rdata,
    output logic        uart_rxd_out,
    output logic        tx_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [29:0]       TX_WORD   = BASE_ADDR[31:2];
    localparam logic [29:0]       ST_WORD   = BASE_ADDR[31:2] + 30'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q;

    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              line_q, line_d;

    logic sel_tx, sel_st;
    logic push_req, push, pop;
    logic fifo_empty, fifo_full;
    logic baud_done;
    logic busy;
    logic [4:0]  count_field;
    logic [31:0] status_word;

    // Address decode ignores the byte lane bits so sb/sh/sw all hit the register
    assign sel_tx  = (bus_addr[31:2] == TX_WORD);
    assign sel_st  = (bus_addr[31:2] == ST_WORD);
    assign bus_sel = sel_tx | sel_st;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);

    // A pop happens exactly when the FSM sits in IDLE with data waiting. A push
    // into a full FIFO is still legal in that cycle because a slot frees up.
    assign pop      = (state_q == S_IDLE) && !fifo_empty;
    assign push_req = bus_we && sel_tx;
    assign push     = push_req && (!fifo_full || pop);

    assign baud_done = (baud_q == BAUD_LAST);

    // FIFO occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            if (bus_we && sel_st)
                overflow_q <= 1'b0;
            else if (push_req && !push)
                overflow_q <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge CLK100MHZ) begin
        if (push) mem_q[wr_ptr_q] <= bus_wdata[7:0];
    end

    // FSM state register
    always_ff @(posedge CLK100MHZ) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_START;
            S_START: if (baud_done) state_d = S_DATA;
            S_DATA:  if (baud_done && (bit_idx_q == 3'd7)) state_d = S_STOP;
            S_STOP:  if (baud_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode: serial level for the current state
    always_comb begin
        line_d = 1'b1;
        case (state_q)
            S_IDLE:  line_d = 1'b1;
            S_START: line_d = 1'b0;
            S_DATA:  line_d = shift_q[0];
            S_STOP:  line_d = 1'b1;
            default: line_d = 1'b1;
        endcase
    end

    // Baud counter, bit index and shift register
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            if (state_q == S_IDLE || baud_done)
                baud_q <= '0;
            else
                baud_q <= baud_q + BAUD_W'(1);

            if (pop)
                shift_q <= mem_q[rd_ptr_q];
            else if (state_q == S_DATA && baud_done)
                shift_q <= {1'b0, shift_q[7:1]};

            if (state_q == S_START)
                bit_idx_q <= '0;
            else if (state_q == S_DATA && baud_done)
                bit_idx_q <= bit_idx_q + 3'd1;
        end
    end

    // Registered serial output; reset forces the line idle on the next edge
    always_ff @(posedge CLK100MHZ) begin
        if (rst) line_q <= 1'b1;
        else     line_q <= line_d;
    end

    assign uart_rxd_out = line_q;

    assign busy    = (state_q != S_IDLE) || !fifo_empty;
    assign tx_busy = busy;

    assign count_field = 5'(count_q);
    assign status_word = {23'd0, count_field, overflow_q, busy, fifo_empty, fifo_full};

    // Read mux: only a STATUS load returns data, everything else reads zero
    always_comb begin
        bus_rdata = 32'd0;
        if (bus_re && sel_st) bus_rdata = status_word;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Stores push expected bytes into exp_q. A line decoder pushes received
// frames into rx_q, with the stop bit in bit 8. Each test pops both queues
// and compares them.

module tb_mmio_uart_tx;

    localparam int          CPB  = 4;
    localparam int          DEP  = 4;
    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk;
    logic        rst;
    logic        bus_we, bus_re;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_sel;
    logic [31:0] bus_rdata;
    logic        uart_rxd_out, tx_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [8:0] rx_q[$];

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .BASE_ADDR(BASE)) dut (
        .CLK100MHZ   (clk),
        .rst         (rst),
        .bus_we      (bus_we),
        .bus_re      (bus_re),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_sel     (bus_sel),
        .bus_rdata   (bus_rdata),
        .uart_rxd_out(uart_rxd_out),
        .tx_busy     (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line decoder: start detected on a falling edge, bits sampled mid-bit
    logic       mon_active = 1'b0;
    logic       mon_prev   = 1'b1;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
            mon_prev   = 1'b1;
        end else begin
            if (!mon_active) begin
                if (mon_prev && !uart_rxd_out) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2)
                    mon_byte[(mon_cnt - 6) / 4] = uart_rxd_out;
                if (mon_cnt == 38) begin
                    mon_active = 1'b0;
                    rx_q.push_back({uart_rxd_out, mon_byte});
                end
            end
            mon_prev = uart_rxd_out;
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
        @(posedge clk); #1;
        bus_re = 1'b1; bus_addr = a;
        #2;
        d = bus_rdata;
        s = bus_sel;
        bus_re = 1'b0;
    endtask

    task automatic check_next_rx(input string name);
        int t = 0;
        logic [8:0] got;
        logic [7:0] want;
        while (rx_q.size() == 0 && t < 150) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (rx_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: no frame received within 150 cycles", name);
        end else if (exp_q.size() == 0) begin
            got = rx_q.pop_front();
            n_err++;
            $display("FAIL %s: unexpected frame got %h, required none", name, got);
        end else begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            if (got !== {1'b1, want}) begin
                n_err++;
                $display("FAIL %s: got frame %h (stop,data) required %h", name, got, {1'b1, want});
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (tx_busy !== 1'b0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: tx_busy still %b after 400 cycles, required 0", name, tx_busy);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic s;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (uart_rxd_out !== 1'b1) begin
            n_err++; $display("FAIL reset_line: got %b required 1", uart_rxd_out);
        end
        n_cmp++;
        if (tx_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b required 0", tx_busy);
        end
        bus_read(BASE + 32'd4, d, s);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_err++; $display("FAIL reset_status: got %h required 00000002", d);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0]  b = 8'h55;
        logic        want;
        logic [31:0] d;
        logic        s;
        exp_q.push_back(b);
        bus_write(BASE, {24'd0, b});
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            if (i <= 2)       want = 1'b1;
            else if (i <= 6)  want = 1'b0;
            else if (i <= 38) want = b[(i - 7) / 4];
            else              want = 1'b1;
            n_cmp++;
            if (uart_rxd_out !== want) begin
                n_err++;
                $display("FAIL wave_55 cycle %0d: got %b required %b", i, uart_rxd_out, want);
            end
        end
        check_next_rx("frame_55");
        bus_read(BASE + 32'd4, d, s);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_err++; $display("FAIL status_after_55: got %h required 00000002", d);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic        s;
        @(posedge clk); #1;
        bus_we = 1'b1; bus_addr = BASE;
        for (int i = 1; i <= 6; i++) begin
            bus_wdata = 32'(i);
            if (i <= 5) exp_q.push_back(8'(i));
            @(posedge clk); #1;
        end
        bus_we = 1'b0;
        bus_read(BASE + 32'd4, d, s);
        n_cmp++;
        if (d !== 32'h0000_004D) begin
            n_err++; $display("FAIL ovf_status: got %h required 0000004d", d);
        end
        bus_write(BASE + 32'd4, 32'hFFFF_FFFF);
        bus_read(BASE + 32'd4, d, s);
        n_cmp++;
        if (d !== 32'h0000_0045) begin
            n_err++; $display("FAIL ovf_clear: got %h required 00000045", d);
        end
        for (int i = 1; i <= 5; i++) check_next_rx($sformatf("ovf_frame_%0d", i));
        wait_idle("ovf_idle");
        n_cmp++;
        if (rx_q.size() != 0) begin
            n_err++; $display("FAIL ovf_extra: got %0d extra frames required 0", rx_q.size());
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] d;
        logic        s;
        @(posedge clk); #1;
        bus_we = 1'b1; bus_addr = BASE;
        for (int i = 0; i < 5; i++) begin
            bus_wdata = 32'h10 + 32'(i);
            exp_q.push_back(8'h10 + 8'(i));
            @(posedge clk); #1;
        end
        bus_we = 1'b0;
        // First frame returns to IDLE 41 edges after the first store; the pop
        // of the next byte happens on the 42nd, with the FIFO still full.
        repeat (37) @(posedge clk);
        #1;
        bus_we = 1'b1; bus_wdata = 32'h15;
        exp_q.push_back(8'h15);
        @(posedge clk); #1;
        bus_we = 1'b0;
        bus_read(BASE + 32'd4, d, s);
        n_cmp++;
        if (d[3] !== 1'b0) begin
            n_err++; $display("FAIL fullpop_ovf: got %b required 0", d[3]);
        end
        n_cmp++;
        if (d !== 32'h0000_0045) begin
            n_err++; $display("FAIL fullpop_status: got %h required 00000045", d);
        end
        for (int i = 0; i < 6; i++) check_next_rx($sformatf("fullpop_frame_%0d", i));
        wait_idle("fullpop_idle");
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic        s;
        int          bad = 0;
        bus_write(BASE, 32'h0000_00A5);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (uart_rxd_out !== 1'b1) begin
            n_err++; $display("FAIL midrst_line: got %b required 1", uart_rxd_out);
        end
        bus_read(BASE + 32'd4, d, s);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_err++; $display("FAIL midrst_status: got %h required 00000002", d);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_rxd_out !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0 || rx_q.size() != 0) begin
            n_err++;
            $display("FAIL midrst_quiet: got %0d low samples, %0d frames required 0 and 0", bad, rx_q.size());
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic        s;
        bus_read(BASE + 32'd8, d, s);
        n_cmp++;
        if (s !== 1'b0 || d !== 32'd0) begin
            n_err++; $display("FAIL dec_base8: got sel %b data %h required sel 0 data 0", s, d);
        end
        bus_read(BASE, d, s);
        n_cmp++;
        if (s !== 1'b1 || d !== 32'd0) begin
            n_err++; $display("FAIL dec_base0: got sel %b data %h required sel 1 data 0", s, d);
        end
        bus_read(BASE + 32'd6, d, s);
        n_cmp++;
        if (s !== 1'b1 || d !== 32'h0000_0002) begin
            n_err++; $display("FAIL dec_base6: got sel %b data %h required sel 1 data 2", s, d);
        end
        @(posedge clk); #1;
        bus_re = 1'b0; bus_addr = BASE + 32'd4;
        #1;
        n_cmp++;
        if (bus_rdata !== 32'd0 || bus_sel !== 1'b1) begin
            n_err++; $display("FAIL dec_no_re: got sel %b data %h required sel 1 data 0", bus_sel, bus_rdata);
        end
        exp_q.push_back(8'h41);
        bus_write(BASE, 32'hDEAD_BE41);
        check_next_rx("sw_deadbe41");
        wait_idle("decode_idle");
    endtask

    initial begin
        rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0;
        bus_addr = 32'd0; bus_wdata = 32'd0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
        test_decode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
